// File: rtl/bus_region_decoder.sv
// Registered base/mask address decoder and single-outstanding bus transaction controller.
// Optional ACCESS watchdog enabled by defining DECODE_TIMEOUT_EN.
module bus_region_decoder #(
    parameter int N_REGIONS = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter logic [N_REGIONS*ADDR_W-1:0] REGION_BASE =
        {32'h08000000, 32'h04010000, 32'h00400000, 32'h00000000},
    parameter logic [N_REGIONS*ADDR_W-1:0] REGION_MASK =
        {32'hFC000000, 32'hFFFFFFF0, 32'hFFFF0000, 32'hFFFFF000},
    parameter int TIMEOUT   = 64
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        req_valid,
    input  logic [ADDR_W-1:0]           req_addr,
    output logic                        req_ready,
    output logic [DATA_W-1:0]           req_rdata,
    output logic                        req_err,
    output logic [N_REGIONS-1:0]        sel,
    input  logic [N_REGIONS-1:0]        slv_ack,
    input  logic [N_REGIONS*DATA_W-1:0] slv_rdata,
    output logic [ADDR_W-1:0]           err_addr,
    output logic [7:0]                  err_count
);

    localparam int IDX_W = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [N_REGIONS-1:0]   r_sel, w_sel_nxt;
    logic                   r_ready, w_ready_nxt;
    logic                   r_err, w_err_nxt;
    logic [DATA_W-1:0]      r_rdata, w_rdata_nxt;
    logic [ADDR_W-1:0]      r_addr, w_addr_nxt;
    logic [IDX_W-1:0]       r_idx, w_idx_nxt;
    logic [ADDR_W-1:0]      r_err_addr, w_err_addr_nxt;
    logic [7:0]             r_err_count, w_err_count_nxt;

    logic [N_REGIONS-1:0]   w_hit;
    logic                   w_any_hit;
    logic [IDX_W-1:0]       w_hit_idx;
    logic                   w_ack;
    logic [DATA_W-1:0]      w_slv_data;
    logic                   w_tmo_expire;

    always_comb begin
        w_hit = '0;
        for (int i = 0; i < N_REGIONS; i++) begin
            w_hit[i] = (req_addr & REGION_MASK[i*ADDR_W +: ADDR_W]) == REGION_BASE[i*ADDR_W +: ADDR_W];
        end
    end

    // Scan downwards so the lowest-index hit is the last one written.
    always_comb begin
        w_any_hit = 1'b0;
        w_hit_idx = '0;
        for (int i = N_REGIONS - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_any_hit = 1'b1;
                w_hit_idx = IDX_W'(i);
            end
        end
    end

    assign w_ack      = slv_ack[r_idx];
    assign w_slv_data = slv_rdata[r_idx*DATA_W +: DATA_W];

`ifdef DECODE_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT);

    logic [TMO_W-1:0] r_tmo_cnt;

    assign w_tmo_expire = (r_state == S_ACCESS) && (r_tmo_cnt == TMO_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tmo_cnt <= '0;
        end else if (r_state != S_ACCESS) begin
            r_tmo_cnt <= '0;
        end else if (!w_ack) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end
`else
    logic w_unused_timeout;

    assign w_tmo_expire     = 1'b0;
    assign w_unused_timeout = (TIMEOUT < 2);
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_sel_nxt       = r_sel;
        w_ready_nxt     = 1'b0;
        w_err_nxt       = 1'b0;
        w_rdata_nxt     = '0;
        w_addr_nxt      = r_addr;
        w_idx_nxt       = r_idx;
        w_err_addr_nxt  = r_err_addr;
        w_err_count_nxt = r_err_count;
        unique case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_addr_nxt = req_addr;
                    if (w_any_hit) begin
                        w_state_nxt = S_ACCESS;
                        w_sel_nxt   = N_REGIONS'(1) << w_hit_idx;
                        w_idx_nxt   = w_hit_idx;
                    end else begin
                        w_state_nxt = S_RESP;
                        w_ready_nxt = 1'b1;
                        w_err_nxt   = 1'b1;
                    end
                end
            end
            S_ACCESS: begin
                // An ack in the expiry cycle still completes normally.
                if (w_ack) begin
                    w_state_nxt = S_RESP;
                    w_sel_nxt   = '0;
                    w_ready_nxt = 1'b1;
                    w_rdata_nxt = w_slv_data;
                end else if (w_tmo_expire) begin
                    w_state_nxt = S_RESP;
                    w_sel_nxt   = '0;
                    w_ready_nxt = 1'b1;
                    w_err_nxt   = 1'b1;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
                if (r_err) begin
                    w_err_addr_nxt = r_addr;
                    if (r_err_count != 8'hFF) begin
                        w_err_count_nxt = r_err_count + 8'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_sel_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_sel       <= '0;
            r_ready     <= 1'b0;
            r_err       <= 1'b0;
            r_rdata     <= '0;
            r_addr      <= '0;
            r_idx       <= '0;
            r_err_addr  <= '0;
            r_err_count <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_sel       <= w_sel_nxt;
            r_ready     <= w_ready_nxt;
            r_err       <= w_err_nxt;
            r_rdata     <= w_rdata_nxt;
            r_addr      <= w_addr_nxt;
            r_idx       <= w_idx_nxt;
            r_err_addr  <= w_err_addr_nxt;
            r_err_count <= w_err_count_nxt;
        end
    end

    assign req_ready = r_ready;
    assign req_rdata = r_rdata;
    assign req_err   = r_err;
    assign sel       = r_sel;
    assign err_addr  = r_err_addr;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_bus_region_decoder.sv
// Scoreboard bench for bus_region_decoder: randomized requests, region map model, latency and error log checks.
module tb_bus_region_decoder;

    localparam int TIMEOUT_P = 64;
`ifdef DECODE_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid;
    logic [31:0]  req_addr;
    logic         req_ready;
    logic [31:0]  req_rdata;
    logic         req_err;
    logic [3:0]   sel;
    logic [3:0]   slv_ack;
    logic [127:0] slv_rdata;
    logic [31:0]  err_addr;
    logic [7:0]   err_count;

    logic         ov_valid;
    logic [31:0]  ov_addr;
    logic         ov_ready;
    logic [31:0]  ov_rdata;
    logic         ov_err;
    logic [1:0]   ov_sel;
    logic [1:0]   ov_ack;
    logic [63:0]  ov_slv_rdata;
    logic [31:0]  ov_err_addr;
    logic [7:0]   ov_err_count;

    always #5 clk = ~clk;

    bus_region_decoder #(.TIMEOUT(TIMEOUT_P)) u_dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready), .req_rdata(req_rdata), .req_err(req_err), .sel(sel),
        .slv_ack(slv_ack), .slv_rdata(slv_rdata), .err_addr(err_addr), .err_count(err_count)
    );

    bus_region_decoder #(
        .N_REGIONS(2),
        .REGION_BASE({32'h00000000, 32'h00000000}),
        .REGION_MASK({32'hFFFFF000, 32'hFFFFF000}),
        .TIMEOUT(TIMEOUT_P)
    ) u_ovl (
        .clk(clk), .reset(reset), .req_valid(ov_valid), .req_addr(ov_addr),
        .req_ready(ov_ready), .req_rdata(ov_rdata), .req_err(ov_err), .sel(ov_sel),
        .slv_ack(ov_ack), .slv_rdata(ov_slv_rdata), .err_addr(ov_err_addr), .err_count(ov_err_count)
    );

    // Region map as read from the address plan, index = region number.
    logic [31:0] rb [4] = '{32'h00000000, 32'h00400000, 32'h04010000, 32'h08000000};
    logic [31:0] rm [4] = '{32'hFFFFF000, 32'hFFFF0000, 32'hFFFFFFF0, 32'hFC000000};

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          cyc;
        logic [31:0] addr;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        m_e;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          m_cnt = 0;
    logic [31:0] m_eaddr = '0;
    bit          pend = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int model_decode(input logic [31:0] a);
        for (int i = 0; i < 4; i++) begin
            if ((a & rm[i]) == rb[i]) return i;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            if (pend) begin
                chk("err_count", 64'(err_count), 64'(m_cnt));
                chk("err_addr", 64'(err_addr), 64'(m_eaddr));
                pend = 1'b0;
            end
            if (req_ready) begin
                chk("sb_pending", 64'(sb_q.size()), 64'd1);
                if (sb_q.size() > 0) begin
                    m_e = sb_q.pop_front();
                    chk("rsp_err", 64'(req_err), 64'(m_e.err));
                    chk("rsp_rdata", 64'(req_rdata), 64'(m_e.rdata));
                    chk("rsp_cycle", 64'(cyc), 64'(m_e.cyc));
                    if (m_e.err) begin
                        m_eaddr = m_e.addr;
                        if (m_cnt < 255) m_cnt++;
                    end
                    pend = 1'b1;
                end
            end else begin
                chk("idle_rdata", 64'(req_rdata), 64'd0);
            end
        end
    end

    // k = ack delay in ACCESS cycles; k == 0 means the slave never acks.
    task automatic do_req(input logic [31:0] addr, input int k, input logic [31:0] data);
        int   idx;
        int   c0;
        int   lat;
        bit   tmo;
        bit   drop;
        logic [3:0] oh;
        exp_t e;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = addr;
        for (int s = 0; s < 4; s++) slv_rdata[s*32 +: 32] = $urandom();
        idx = model_decode(addr);
        c0  = cyc;
        if (idx < 0) begin
            e = '{1'b1, 32'h0, c0 + 1, addr};
            sb_q.push_back(e);
            @(negedge clk);
            chk("miss_sel", 64'(sel), 64'd0);
            @(negedge clk);
            req_valid = 1'b0;
            return;
        end
        slv_rdata[idx*32 +: 32] = data;
        oh   = 4'b0001 << idx;
        tmo  = TMO_EN && (k == 0 || k > TIMEOUT_P);
        lat  = tmo ? TIMEOUT_P : k;
        drop = ($urandom_range(0, 5) == 0);
        e = '{tmo, tmo ? 32'h0 : data, c0 + lat + 1, addr};
        sb_q.push_back(e);
        for (int j = 1; j <= lat; j++) begin
            @(negedge clk);
            chk("sel_hold", 64'(sel), 64'(oh));
            slv_ack = 4'($urandom()) & ~oh;
            if (!tmo && j == k) slv_ack = slv_ack | oh;
            if (drop && j == 1) req_valid = 1'b0;
        end
        @(negedge clk);
        slv_ack = '0;
        chk("resp_sel", 64'(sel), 64'd0);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int          r;
        reset = 1'b1;
        req_valid = 1'b0; req_addr = '0; slv_ack = '0; slv_rdata = '0;
        ov_valid = 1'b0; ov_addr = '0; ov_ack = '0; ov_slv_rdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_sel", 64'(sel), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_err", 64'(req_err), 64'd0);
        chk("rst_rdata", 64'(req_rdata), 64'd0);
        chk("rst_err_addr", 64'(err_addr), 64'd0);
        chk("rst_err_count", 64'(err_count), 64'd0);
        reset = 1'b0;

        do_req(32'h08000010, 1, 32'hDEADBEEF);
        do_req(32'h00400004, 5, 32'hCAFE0001);
        do_req(32'h20000000, 1, 32'h0);
        chk("miss_err_addr", 64'(err_addr), 64'h20000000);
        chk("miss_err_count", 64'(err_count), 64'd1);

        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 4);
            if (r < 4) a = rb[r] | ($urandom() & ~rm[r]);
            else       a = $urandom();
            do_req(a, $urandom_range(1, 8), $urandom());
        end

        @(negedge clk);
        ov_valid = 1'b1; ov_addr = 32'h0;
        ov_slv_rdata = {32'h0BAD0BAD, 32'h12345678};
        @(negedge clk);
        chk("ovl_sel", 64'(ov_sel), 64'h1);
        ov_ack = 2'b10;
        @(negedge clk);
        chk("ovl_sel_hold", 64'(ov_sel), 64'h1);
        chk("ovl_no_ready", 64'(ov_ready), 64'd0);
        ov_ack = 2'b01;
        @(negedge clk);
        ov_ack = 2'b00;
        chk("ovl_ready", 64'(ov_ready), 64'd1);
        chk("ovl_rdata", 64'(ov_rdata), 64'h12345678);
        chk("ovl_err", 64'(ov_err), 64'd0);
        chk("ovl_resp_sel", 64'(ov_sel), 64'd0);
        @(negedge clk);
        ov_valid = 1'b0;

        for (int n = 0; n < 300; n++) do_req(32'h20000000, 1, 32'h0);
        chk("sat_err_count", 64'(err_count), 64'd255);

        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h00400010; slv_ack = '0;
        repeat (3) @(negedge clk);
        chk("rst_mid_sel", 64'(sel), 64'h2);
        reset = 1'b1;
        req_valid = 1'b0;
        sb_q.delete();
        m_cnt = 0; m_eaddr = '0; pend = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_mid_sel0", 64'(sel), 64'd0);
        chk("rst_mid_ready", 64'(req_ready), 64'd0);
        chk("rst_mid_err_count", 64'(err_count), 64'd0);
        chk("rst_mid_err_addr", 64'(err_addr), 64'd0);
        repeat (3) begin
            @(negedge clk);
            chk("rst_mid_no_ready", 64'(req_ready), 64'd0);
        end
        do_req(32'h00400010, 2, 32'h5A5A1234);

`ifdef DECODE_TIMEOUT_EN
        do_req(32'h04010000, 0, 32'h0);
        chk("tmo_err_count", 64'(err_count), 64'd1);
        chk("tmo_err_addr", 64'(err_addr), 64'h04010000);
        do_req(32'h04010004, TIMEOUT_P, 32'h600DF00D);
        chk("tmo_edge_err_count", 64'(err_count), 64'd1);
`endif

        repeat (4) @(negedge clk);
        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_region_decoder.md
# bus_region_decoder

Registered, parametrised address decoder and bus-transaction controller between the RISC-V core's data port and its memory-mapped slaves (ROM, IO, graphics, RAM). It matches each request against N base/mask regions, drives a one-hot slave select for the duration of the access, and waits for the selected slave's acknowledge. It then returns a single-cycle completion with read data. Unmapped accesses, and optionally unresponsive slaves, complete with a bus error, and the faulting address is logged.

## Interface
- N_REGIONS, 4, number of decoded regions (1..16).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- REGION_BASE, {32'h08000000, 32'h04010000, 32'h00400000, 32'h00000000}, packed N_REGIONS*ADDR_W; region i occupies bits [i*ADDR_W +: ADDR_W].
- REGION_MASK, {32'hFC000000, 32'hFFFFFFF0, 32'hFFFF0000, 32'hFFFFF000}, packed like REGION_BASE; region i hits when (addr & MASK[i]) == BASE[i].
- TIMEOUT, 64, cycles allowed in ACCESS before abort (only used with DECODE_TIMEOUT_EN); must be ≥2.
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  core request; held high until req_ready.
- req_addr  in  ADDR_W  request address; stable while req_valid.
- req_ready  out  1  one-cycle completion pulse.
- req_rdata  out  DATA_W  read data, valid with req_ready; 0 otherwise.
- req_err  out  1  bus error, valid with req_ready.
- sel  out  N_REGIONS  one-hot slave select, registered.
- slv_ack  in  N_REGIONS  per-slave completion strobe.
- slv_rdata  in  N_REGIONS*DATA_W  per-slave read data, slice i at [i*DATA_W +: DATA_W].
- err_addr  out  ADDR_W  address of the most recent errored request.
- err_count  out  8  saturating count of errored requests.

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: on req_valid, register req_addr and compute hits for all regions.
  - On overlapping hits, the lowest index wins.
  - On a hit, go to ACCESS with sel[idx]=1.
  - On no hit, go to RESP with req_err=1 and rdata 0.
- ACCESS: sel held. When slv_ack[idx]=1, capture slv_rdata slice idx and go to RESP with err=0. Acks on unselected lines are ignored.
- RESP: req_ready=1 for exactly one cycle, sel=0, then IDLE. A new request is evaluated in IDLE no earlier than the cycle after RESP.
- On any error completion:
  - err_addr is loaded with the registered address.
  - err_count increments, saturating at 255.
- If req_valid drops mid-ACCESS (protocol violation), the access still completes normally.
- Reset (any state) gives:
  - state IDLE;
  - sel=0, req_ready=0, req_err=0, req_rdata=0;
  - err_addr=0, err_count=0;
  - timeout counter=0.
  - An interrupted access produces no req_ready.

## Timing
- Cycle t: IDLE samples req_valid=1.
- Hit:
  - sel is high from t+1.
  - A slave acking in cycle t+k (k≥1) gives req_ready in t+k+1.
  - Minimum latency is therefore valid→ready = 2 cycles (ack in t+1, ready in t+2).
- Miss: req_ready with req_err=1 in t+1. sel is never asserted.
- sel deasserts in the RESP cycle. The slave must not ack again until re-selected.
- err_addr and err_count update on the edge ending the RESP cycle and are visible from the cycle after req_ready.
- Reset asserted in cycle r: all outputs take their reset values from r+1.

## Configuration
- DECODE_TIMEOUT_EN defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle without ack.
  - When the count reaches TIMEOUT-1 with no ack in that cycle, the block goes to RESP with req_err=1 and rdata 0. This logs err_addr/err_count.
  - An ack in the same cycle as expiry wins (normal completion).
- DECODE_TIMEOUT_EN undefined: no counter logic. ACCESS waits indefinitely for ack.

## Test plan
- Default params, read 0x08000010, slv_ack[3] one cycle after sel with data 0xDEADBEEF -> sel=4'b1000 from t+1, req_ready at t+2 with rdata 0xDEADBEEF, err=0.
- Read 0x00400004, ack[1] delayed 5 cycles -> sel=4'b0010 held for exactly 5 cycles, one ready pulse, no other sel bits set.
- Read unmapped 0x20000000 -> req_ready at t+1 with err=1, sel stays 0, err_addr=0x20000000, err_count=1. Repeat 300× -> err_count=255.
- Overlap: set REGION_BASE[1]=REGION_BASE[0]=0, masks equal, read 0x0 -> only sel[0]=1.
- DECODE_TIMEOUT_EN, TIMEOUT=64, read 0x04010000, no ack -> err=1 response exactly 64 cycles after sel rises. Ack on exactly cycle 64 -> normal completion, err=0.
- Assert reset for one cycle mid-ACCESS -> sel=0 next cycle, no req_ready, err_count=0. A following request completes normally.
